// File: rtl/fc_pkg.sv
// Shared types and saturating arithmetic for the parallel fully-connected layer.
package fc_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StLoad} fc_state_e;

  // Cycles after the last issue until the final product has been accumulated.
  localparam int unsigned DrainCycles = 3;

  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

  function automatic longint sat_clip(input longint v, input int unsigned w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < sat_min(w)) return sat_min(w);
    return v;
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input int unsigned w);
    return sat_clip(a + b, w);
  endfunction

  function automatic longint sat_mul(input longint a, input longint b, input int unsigned w);
    return sat_clip(a * b, w);
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: private weight bank, operand register, product register and
// saturating accumulator with synchronous clear.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w_wr_en,
  input  logic [AddrW-1:0]        w_addr,
  input  logic [Width-1:0]        w_data,
  input  logic [AddrW-1:0]        rd_addr,
  input  logic [Width-1:0]        x_data,
  input  logic                    issue,
  input  logic                    clear,
  output logic signed [Width-1:0] acc
);

  logic signed [Width-1:0] wmem [Depth];
  logic signed [Width-1:0] w_op_q, x_op_q, prod_q, acc_q;
  logic                    v1_q, v2_q;

  // Weight bank is not reset; contents survive a layer reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) wmem[w_addr] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_op_q <= '0;
      x_op_q <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      v1_q <= issue;
      if (issue) begin
        w_op_q <= wmem[rd_addr];
        x_op_q <= x_data;
      end
      v2_q <= v1_q;
      if (v1_q) prod_q <= Width'(sat_mul(longint'(w_op_q), longint'(x_op_q), Width));
      if (clear) begin
        acc_q <= '0;
      end else if (v2_q) begin
        acc_q <= Width'(sat_add(longint'(acc_q), longint'(prod_q), Width));
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fc_layer_par.sv
// Fully-connected layer y = act(W*x) with P parallel MAC lanes, a double-buffered
// input vector, run-time weight loading and valid/ready streaming on both sides.
module fc_layer_par
  import fc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned M     = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned P     = 2,
  parameter bit          RELU  = 1'b1,
  localparam int unsigned LaneW = (P > 1) ? $clog2(P) : 1,
  localparam int unsigned AddrW = $clog2(M / P * N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [WIDTH-1:0] input_data,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [WIDTH-1:0] output_data,
  input  logic             w_wr_en,
  input  logic [LaneW-1:0] w_lane,
  input  logic [AddrW-1:0] w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic             w_ready
);

  localparam int unsigned G    = M / P;
  localparam int unsigned Bank = G * N;
  localparam int unsigned NW   = $clog2(N);
  localparam int unsigned GW   = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned OW   = (P > 1) ? $clog2(P) : 1;

  if (M % P != 0) begin : g_bad_p
    $error("fc_layer_par: M must be a multiple of P");
  end

  fc_state_e               state_q;
  logic [NW-1:0]           n_q, wr_idx_q;
  logic [GW-1:0]           g_q;
  logic [1:0]              drain_q;
  logic [1:0]              full_q;
  logic                    wr_bank_q, rd_bank_q, ready_en_q;
  logic [WIDTH-1:0]        x_mem [2][N];
  logic [WIDTH-1:0]        x_rd;
  logic signed [WIDTH-1:0] acc [P];
  logic [WIDTH-1:0]        out_buf_q [P];
  logic [OW-1:0]           out_idx_q;
  logic                    out_valid_q;
  logic                    in_fire, in_last, out_fire, issue, load_go, start;
  logic [AddrW-1:0]        rd_addr;

  assign input_ready  = ready_en_q && !(full_q[0] && full_q[1]);
  assign in_fire      = input_valid && input_ready;
  assign in_last      = in_fire && (wr_idx_q == NW'(N - 1));
  assign out_fire     = out_valid_q && output_ready;
  assign w_ready      = (state_q == StIdle);
  assign issue        = (state_q == StRun);
  assign load_go      = (state_q == StLoad) && !out_valid_q;
  assign rd_addr      = AddrW'(32'(g_q) * N + 32'(n_q));
  assign x_rd         = x_mem[rd_bank_q][n_q];
  assign output_valid = out_valid_q;
  assign output_data  = out_buf_q[out_idx_q];
  // A bank completing on this edge may start compute immediately.
  assign start        = full_q[rd_bank_q] || (in_last && (wr_bank_q == rd_bank_q));

  always_ff @(posedge clk) begin
    if (in_fire) x_mem[wr_bank_q][wr_idx_q] <= input_data;
  end

  for (genvar k = 0; k < P; k++) begin : g_lane
    fc_mac_lane #(
      .Width(WIDTH),
      .Depth(Bank),
      .AddrW(AddrW)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .w_wr_en(w_wr_en && w_ready && (w_lane == LaneW'(k))),
      .w_addr (w_addr),
      .w_data (w_data),
      .rd_addr(rd_addr),
      .x_data (x_rd),
      .issue  (issue),
      .clear  (load_go),
      .acc    (acc[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      n_q         <= '0;
      g_q         <= '0;
      drain_q     <= '0;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      ready_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      for (int k = 0; k < P; k++) out_buf_q[k] <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (in_fire) begin
        if (in_last) begin
          wr_idx_q          <= '0;
          wr_bank_q         <= ~wr_bank_q;
          full_q[wr_bank_q] <= 1'b1;
        end else begin
          wr_idx_q <= wr_idx_q + 1'b1;
        end
      end
      if (out_fire) begin
        if (out_idx_q == OW'(P - 1)) begin
          out_valid_q <= 1'b0;
          out_idx_q   <= '0;
        end else begin
          out_idx_q <= out_idx_q + 1'b1;
        end
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            g_q     <= '0;
            n_q     <= '0;
          end
        end
        StRun: begin
          if (n_q == NW'(N - 1)) begin
            state_q <= StDrain;
            n_q     <= '0;
            drain_q <= '0;
          end else begin
            n_q <= n_q + 1'b1;
          end
        end
        StDrain: begin
          if (drain_q == 2'(DrainCycles - 1)) state_q <= StLoad;
          else drain_q <= drain_q + 1'b1;
        end
        StLoad: begin
          // Uses the registered empty flag, so a same-cycle final accept costs one wait cycle.
          if (!out_valid_q) begin
            for (int k = 0; k < P; k++) out_buf_q[k] <= (RELU && acc[k][WIDTH-1]) ? '0 : acc[k];
            out_valid_q <= 1'b1;
            out_idx_q   <= '0;
            if (g_q == GW'(G - 1)) begin
              full_q[rd_bank_q] <= 1'b0;
              rd_bank_q         <= ~rd_bank_q;
              state_q           <= StIdle;
            end else begin
              g_q     <= g_q + 1'b1;
              state_q <= StRun;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
